// File: rtl/aes_round_sequencer_pkg.sv
// Shared AES-128 types, round constants, sequencer FSM encoding and GF(2^8) helpers
// used by the iterative round sequencer and its combinational round stages.
package CipherNoOpaques_defs;

    typedef logic [7:0]  t_aes_byte;
    typedef logic [31:0] t_aes_word;

    // Indexed [column][row]: element [0][0] occupies bits 127:120 (FIPS-197 byte order).
    typedef logic [0:3][0:3][7:0] t_opaque_AESState;

    localparam int NUM_ROUNDS_DEFAULT = 10;

    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } t_seq_state;

    function automatic t_aes_byte xtime(input t_aes_byte b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic t_aes_byte gf_mul(input t_aes_byte a, input t_aes_byte b);
        t_aes_byte acc;
        t_aes_byte aa;
        acc = '0;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // S-box computed as the affine map of the field inverse (x^254, so 0 maps to 0).
    function automatic t_aes_byte sbox(input t_aes_byte x);
        t_aes_byte inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gf_mul(inv, inv);
            if (i != 0) inv = gf_mul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic t_aes_byte rcon_of(input logic [3:0] r);
        t_aes_byte res;
        res = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            if (r == 4'(i)) res = RCON[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Stream interface of the AES round sequencer: plaintext/key in, ciphertext out.
interface aes_round_sequencer_if;
    import CipherNoOpaques_defs::*;

    // Handshake: a transfer happens on a rising clk edge where valid and ready are both
    // high. Once valid rises it stays high with a stable payload until that edge, and
    // ready never depends combinationally on the valid of the same channel.
    logic             in_valid;
    logic             in_ready;
    t_opaque_AESState in_text;
    logic [127:0]     in_key;
    logic             out_valid;
    logic             out_ready;
    t_opaque_AESState out_text;
    logic             busy;

    modport master (
        output in_valid, in_text, in_key, out_ready,
        input  in_ready, out_valid, out_text, busy
    );

    modport slave (
        input  in_valid, in_text, in_key, out_ready,
        output in_ready, out_valid, out_text, busy
    );

endinterface

// File: rtl/aes_round_sequencer_stages.sv
// Combinational AES round stages (subBytes, shiftRows, mixColumns, addRoundKey)
// and the one-step on-the-fly AES-128 key expansion used by the sequencer.
module subBytes
    import CipherNoOpaques_defs::*;
(
    input  t_opaque_AESState state_in,
    output t_opaque_AESState state_out
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign state_out[c][r] = sbox(state_in[c][r]);
        end
    end
endmodule

module shiftRows
    import CipherNoOpaques_defs::*;
(
    input  t_opaque_AESState state_in,
    output t_opaque_AESState state_out
);
    // Row r rotates left by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign state_out[c][r] = state_in[(c + r) % 4][r];
        end
    end
endmodule

module mixColumns
    import CipherNoOpaques_defs::*;
(
    input  t_opaque_AESState state_in,
    output t_opaque_AESState state_out
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        t_aes_byte a0, a1, a2, a3;
        assign a0 = state_in[c][0];
        assign a1 = state_in[c][1];
        assign a2 = state_in[c][2];
        assign a3 = state_in[c][3];
        assign state_out[c][0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign state_out[c][1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign state_out[c][2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign state_out[c][3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
endmodule

module addRoundKey
    import CipherNoOpaques_defs::*;
(
    input  t_opaque_AESState state_in,
    input  logic [127:0]     round_key,
    output t_opaque_AESState state_out
);
    assign state_out = state_in ^ round_key;
endmodule

module key_expand_step
    import CipherNoOpaques_defs::*;
(
    input  logic [127:0] key_in,
    input  t_aes_byte    rcon,
    output logic [127:0] key_out
);
    t_aes_word w0, w1, w2, w3;
    t_aes_word rot, sub, temp;
    t_aes_word n0, n1, n2, n3;

    assign w0 = key_in[127:96];
    assign w1 = key_in[95:64];
    assign w2 = key_in[63:32];
    assign w3 = key_in[31:0];

    assign rot  = {w3[23:0], w3[31:24]};
    assign sub  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign temp = sub ^ {rcon, 24'h000000};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_out = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor: one cipher round per clock over shared round stages.
// Define AES_ROUND_TAP_EN to expose round_idx/round_state for intermediate-value checks.
module aes_round_sequencer
    import CipherNoOpaques_defs::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_round_sequencer_if.slave bus,
`ifdef AES_ROUND_TAP_EN
    output logic [3:0]           round_idx,
    output t_opaque_AESState     round_state,
`endif
    output t_seq_state           dbg_state
);

    if (NUM_ROUNDS != 10) begin : g_bad_rounds
        $error("aes_round_sequencer: only NUM_ROUNDS = 10 (AES-128) is supported");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    t_seq_state       state_q, state_d;
    logic [3:0]       round_q, round_d;
    t_opaque_AESState state_reg, text_d;
    logic [127:0]     rk_reg, rk_d, rk_next;
    t_aes_byte        rcon_cur;
    logic             last_round;
    logic             accept;
    logic             in_ready_c;

    t_opaque_AESState sb_out, sr_out, mc_out, mix_sel, round_out;

    assign rcon_cur   = rcon_of(round_q);
    assign last_round = (round_q == LAST_ROUND);

    subBytes u_sub_bytes (
        .state_in  (state_reg),
        .state_out (sb_out)
    );

    shiftRows u_shift_rows (
        .state_in  (sb_out),
        .state_out (sr_out)
    );

    mixColumns u_mix_columns (
        .state_in  (sr_out),
        .state_out (mc_out)
    );

    // The final round skips mixColumns.
    assign mix_sel = last_round ? sr_out : mc_out;

    key_expand_step u_key_expand (
        .key_in  (rk_reg),
        .rcon    (rcon_cur),
        .key_out (rk_next)
    );

    addRoundKey u_add_round_key (
        .state_in  (mix_sel),
        .round_key (rk_next),
        .state_out (round_out)
    );

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        text_d     = state_reg;
        rk_d       = rk_reg;
        accept     = 1'b0;
        in_ready_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                text_d  = round_out;
                rk_d    = rk_next;
                round_d = last_round ? round_q : round_q + 4'd1;
                if (last_round) state_d = ST_DONE;
            end
            ST_DONE: begin
                // Releasing the result frees the datapath, so a new block may enter on the same edge.
                in_ready_c = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        accept  = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            text_d  = bus.in_text ^ bus.in_key;
            rk_d    = bus.in_key;
            round_d = 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            round_q   <= '0;
            state_reg <= '0;
            rk_reg    <= '0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            state_reg <= text_d;
            rk_reg    <= rk_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_text  = state_reg;
    assign bus.busy      = (state_q != ST_IDLE);
    assign dbg_state     = state_q;

`ifdef AES_ROUND_TAP_EN
    assign round_idx   = round_q;
    assign round_state = state_reg;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed FIPS-197 vector bench for aes_round_sequencer with a queue-based scoreboard;
// also checks the AES_ROUND_TAP_EN taps when that macro is defined.
module tb_aes_round_sequencer;
    import CipherNoOpaques_defs::*;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] R1_B  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    t_seq_state dbg_state;
`ifdef AES_ROUND_TAP_EN
    logic [3:0]       round_idx;
    t_opaque_AESState round_state;
    bit               tap_b_run = 1'b0;
`endif

    aes_round_sequencer_if bus ();

    aes_round_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
`ifdef AES_ROUND_TAP_EN
        .round_idx   (round_idx),
        .round_state (round_state),
`endif
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: a handshake completes on the posedge following a negedge with valid && ready.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %h want no output", bus.out_text);
            end else begin
                check("out_text", bus.out_text, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [127:0] pt, input logic [127:0] key,
                        input logic [127:0] exp, input bit push);
        int waited;
        bus.in_valid = 1'b1;
        bus.in_text  = pt;
        bus.in_key   = key;
        #1;
        waited = 0;
        while (!bus.in_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready got 0 want 1");
        end
        @(posedge clk);
        if (push) exp_q.push_back(exp);
        #1;
        // Scramble inputs after acceptance: they must have no effect on the block in flight.
        bus.in_valid = 1'b0;
        bus.in_text  = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Counts edges from the accepting edge (inclusive) to the edge after which out_valid is seen.
    task automatic wait_valid(input string name);
        int n;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check({name, "_busy"}, 128'(bus.busy), 128'd1);
                check({name, "_in_ready"}, 128'(bus.in_ready), 128'd0);
            end
`ifdef AES_ROUND_TAP_EN
            if (i < 10) check({name, "_round_idx"}, 128'(round_idx), 128'(i + 1));
            if (i == 1 && tap_b_run) check({name, "_round1_state"}, round_state, R1_B);
`endif
            if (bus.out_valid) break;
            @(posedge clk);
            n++;
        end
        check({name, "_latency"}, 128'(n), 128'd11);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_text   = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_out_text", bus.out_text, 128'd0);
        check("rst_state", 128'(dbg_state), 128'(ST_IDLE));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 128'(bus.in_ready), 128'd1);

        // FIPS-197 App. B, inputs scrambled during RUN
`ifdef AES_ROUND_TAP_EN
        tap_b_run = 1'b1;
`endif
        send(PT_B, KEY_B, CT_B, 1'b1);
        wait_valid("app_b");
        @(posedge clk);
        #1;
`ifdef AES_ROUND_TAP_EN
        tap_b_run = 1'b0;
`endif

        // FIPS-197 App. C.1
        send(PT_C, KEY_C, CT_C, 1'b1);
        wait_valid("app_c");
        @(posedge clk);
        @(negedge clk);
        check("idle_busy", 128'(bus.busy), 128'd0);
        check("idle_out_valid", 128'(bus.out_valid), 128'd0);
        check("idle_in_ready", 128'(bus.in_ready), 128'd1);
        @(posedge clk);
        #1;

        // Backpressure then back-to-back acceptance
        bus.out_ready = 1'b0;
        send(PT_B, KEY_B, CT_B, 1'b1);
        wait_valid("bp");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_out_text", bus.out_text, CT_B);
            check("bp_out_valid", 128'(bus.out_valid), 128'd1);
            check("bp_in_ready", 128'(bus.in_ready), 128'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(PT_C, KEY_C, CT_C, 1'b1);
        wait_valid("b2b");
        @(posedge clk);
        #1;

        // Reset asserted while round 5 is pending
        send(PT_B, KEY_B, CT_B, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 128'(bus.out_valid), 128'd0);
        check("midrst_busy", 128'(bus.busy), 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_in_ready", 128'(bus.in_ready), 128'd1);
        check("postrst_out_valid", 128'(bus.out_valid), 128'd0);
        check("postrst_state", 128'(dbg_state), 128'(ST_IDLE));
        @(posedge clk);
        #1;
        send(PT_B, KEY_B, CT_B, 1'b1);
        wait_valid("after_rst");
        @(posedge clk);
        #1;

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Iterative AES-128 encryption controller: one plaintext/key pair in, one ciphertext out, one cipher round per clock.
- Time-multiplexes a single instance of each round datapath stage: subBytes, shiftRows, mixColumns and addRoundKey.
- Expands the round key on the fly, one step per round.
- Sits between the cipher's valid/ready stream interface and the combinational round stages, replacing the fully unrolled cipher where area matters.

Parameters:
- NUM_ROUNDS, 10, total cipher rounds. Only 10 (AES-128) is supported; any other value is an elaboration error.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- in_valid  input  1  plaintext and key are valid.
- in_ready  output  1  block accepts input this cycle.
- in_text  input  t_opaque_AESState  plaintext. FIPS byte order: bits 127:120 map to state[0][0], column-major.
- in_key  input  128  cipher key, same byte order.
- out_valid  output  1  ciphertext is valid.
- out_ready  input  1  consumer accepts output.
- out_text  output  t_opaque_AESState  ciphertext.
- busy  output  1  a block is in flight (RUN or DONE).

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE, round = 0.
  - state_reg, rk_reg, out_text = all zero.
  - out_valid = 0, busy = 0, in_ready = 1 once reset releases.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: state_reg <= in_text xor in_key; rk_reg <= in_key; round <= 1; go to RUN.
- RUN (round r = 1..10), in_ready = 0:
  - rk_next = key_expand_step(rk_reg, RCON[r]).
  - For r < 10: state_reg <= mixColumns(shiftRows(subBytes(state_reg))) xor rk_next.
  - For r = 10: mixColumns is bypassed.
  - rk_reg <= rk_next; round <= r + 1.
  - After r = 10: go to DONE and set out_valid = 1.
- RCON sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36 (bytes).
- Latency:
  - Input is accepted at edge T.
  - out_valid is high from the cycle after edge T+10, i.e. 11 cycles from acceptance.
  - Throughput: one block per 11 cycles.
- DONE:
  - out_text = state_reg, held stable while out_valid = 1 and out_ready = 0.
  - in_ready = out_ready.
  - out_ready and in_valid both high: output completes and the new input is accepted in the same edge (back-to-back); go to RUN, round = 1.
  - out_ready high, in_valid low: go to IDLE, out_valid = 0.
- in_ready never depends combinationally on in_valid. out_valid never drops without out_ready.
- in_text and in_key are sampled only at the accepting edge. Later changes have no effect.
- Round counter: 4 bits, saturates; never wraps past 10.
- Reset asserted mid-operation: the in-flight block is discarded, no partial output is presented, and the block returns to the reset state above.
- busy = 1 in RUN and DONE, 0 in IDLE.

Optional Feature:
- Macro: AES_ROUND_TAP_EN.
- Defined:
  - Adds ports round_idx (output, 4 bits) and round_state (output, t_opaque_AESState).
  - round_idx equals the round register.
  - round_state equals state_reg.
  - Both are registered, with no extra latency.
  - Used for FIPS-197 Appendix B intermediate-value checking.
- Undefined: the ports are absent. Core behaviour is identical.

Decomposition:
- Shared package CipherNoOpaques_defs holds:
  - t_opaque_AESState (4x4 bytes) and the AES byte/word typedefs.
  - RCON table constant.
  - FSM state enum.
  - NUM_ROUNDS default.
- Existing modules are instantiated once each: subBytes, shiftRows, mixColumns, addRoundKey.
- One new sub-module: key_expand_step.
  - Combinational.
  - Inputs: the 128-bit key and an RCON byte.
  - Output: the next round key, computed as RotWord, SubWord, xor RCON, then chained word xors.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_text 3925841d02dc09fbdc118597196a0b32, out_valid exactly 11 cycles after acceptance.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: hold out_ready = 0 for 20 cycles after out_valid -> out_text stable, in_ready = 0. Then out_ready = 1 with in_valid = 1 -> new block accepted the same edge, second result (App. C.1) after 11 more cycles.
- Input change after acceptance: alter in_text/in_key during RUN -> result still matches the sampled App. B vector.
- Reset mid-RUN at round 5: rst_n low for 1 cycle -> out_valid = 0, busy = 0, in_ready = 1. A fresh App. B run then gives the correct ciphertext.
- With AES_ROUND_TAP_EN: round_state after round 1 of App. B = a49c7ff2689f352b6b5bea43026a5049, round_idx steps 1..10.
